// File: rtl/mod_counter_pkg.sv
// Shared constants and helpers for the modulo-N counter.
// Pure package: no state, no latency, no flow control.
package mod_counter_pkg;

    localparam logic CNT_UP = 1'b1;
    localparam logic CNT_DN = 1'b0;

    // Supports counters up to 32 bits; callers narrow the result to their width.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/mod_n_next.sv
// Next-count and wrap-condition logic for a modulo-N up/down counter.
// Purely combinational, zero latency; no flow control.
module mod_n_next
    import mod_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up_dn,
    output logic [WIDTH-1:0] nxt,
    output logic             wrap_cond
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

    // Explicit terminal compare also covers MODULUS = 2**WIDTH, where it
    // coincides exactly with the natural binary rollover.
    always_comb begin
        nxt       = q;
        wrap_cond = 1'b0;
        if (up_dn == CNT_UP) begin
            if (q == MAXV) begin
                nxt       = '0;
                wrap_cond = 1'b1;
            end else begin
                nxt = q + 1'b1;
            end
        end else begin
            if (q == '0) begin
                nxt       = MAXV;
                wrap_cond = 1'b1;
            end else begin
                nxt = q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mod_n_counter.sv
// Modulo-N up/down counter with clear, range-checked load, Gray and wrap outputs.
// q/wrap/load_err update one cycle after the controlling edge; qb/q_gray/tc are combinational.
// No backpressure: one action (reset > clr > load > en > hold) is applied every edge.
module mod_n_counter
    import mod_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic [WIDTH-1:0] q_gray,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 ||
        longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_param
        $error("mod_n_counter: need 2 <= MODULUS <= 2**WIDTH and 1 <= WIDTH <= 32");
    end

    // One extra bit so MODULUS = 2**WIDTH is representable for the load check.
    localparam logic [WIDTH:0] MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] nxt;
    logic             wrap_cond;

    mod_n_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .q         (q),
        .up_dn     (up_dn),
        .nxt       (nxt),
        .wrap_cond (wrap_cond)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            q        <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
            if (clr) begin
                q <= '0;
            end else if (load) begin
                if ({1'b0, load_val} < MOD_EXT) begin
                    q <= load_val;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (en) begin
                q    <= nxt;
                wrap <= wrap_cond;
            end
        end
    end

    assign qb     = ~q;
    assign q_gray = WIDTH'(bin2gray(32'(q)));
    assign tc     = wrap_cond;

endmodule
